// File: rtl/jtkicker_prog_buf.sv
// jtkicker_prog_buf
// Write buffer between the ROM download stage and the SDRAM programming port.
// Byte writes arriving during a download are queued in a 2**AW entry FIFO and
// replayed one at a time to the SDRAM with a prog_we/sdram_ack handshake.
//
// Optional feature: define PROG_BUF_SWIZZLE_EN to rearrange the low address
// bits of scroll/object GFX writes on push (regions set by SCR_START,
// OBJ_START, PCM_START). Without it addresses are stored unmodified.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   downloading       download in progress (rising edge clears ovf)
//   din_we/addr/data/mask   one-cycle write strobe and its payload
//   prog_we/addr/data/mask  registered write request presented to SDRAM
//   sdram_ack         one-cycle acknowledge of the current prog_we
//   dwnld_busy        download not yet fully committed to SDRAM
//   full              FIFO holds 2**AW entries
//   ovf               sticky: a write was dropped because the FIFO was full
module jtkicker_prog_buf #(
  parameter int          AW        = 4,
  parameter logic [21:0] SCR_START = 22'h0,
  parameter logic [21:0] OBJ_START = 22'h0,
  parameter logic [21:0] PCM_START = 22'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        din_we,
  input  logic [21:0] din_addr,
  input  logic [7:0]  din_data,
  input  logic [1:0]  din_mask,
  output logic        prog_we,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  input  logic        sdram_ack,
  output logic        dwnld_busy,
  output logic        full,
  output logic        ovf
);

`ifdef PROG_BUF_SWIZZLE_EN
  localparam bit SWZ_EN = 1'b1;
`else
  localparam bit SWZ_EN = 1'b0;
`endif

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } entry_t;

  // Range tests done as borrow checks on 23-bit differences so that a zero
  // region bound never turns into a constant comparison.
  function automatic logic [21:0] swizzle(input logic [21:0] s);
    logic [22:0] d_scr, d_obj, d_pcm;
    logic [21:0] r;
    d_scr = {1'b0, s} - {1'b0, SCR_START};
    d_obj = {1'b0, s} - {1'b0, OBJ_START};
    d_pcm = {1'b0, s} - {1'b0, PCM_START};
    r     = s;
    if (!d_scr[22] && d_obj[22]) begin
      r[0]   = ~s[3];
      r[3:1] = s[2:0];
    end else if (!d_obj[22] && d_pcm[22]) begin
      r[0]   = ~s[3];
      r[1]   = ~s[4];
      r[5:2] = {s[5], s[2:0]};
    end
    return r;
  endfunction

  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t      state_q, state_d;
  entry_t      out_q, out_d;
  logic        prog_we_q, prog_we_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic        dl_q;
  logic        empty, full_w, pop, push, drop;
  logic [21:0] push_addr;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_w = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // The head is only released by an ack while it is being presented.
  assign pop    = (state_q == WAIT) && sdram_ack;
  // A full FIFO still accepts a write in the same cycle the head leaves.
  assign push   = din_we && (!full_w || pop);
  assign drop   = din_we && full_w && !pop;

  assign push_addr = SWZ_EN ? swizzle(din_addr) : din_addr;

  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{push_addr, din_data, din_mask};
  end

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    prog_we_d = prog_we_q;
    case (state_q)
      IDLE: if (!empty) begin
        out_d     = mem_q[rd_ptr_q[AW-1:0]];
        prog_we_d = 1'b1;
        state_d   = WAIT;
      end
      WAIT: if (sdram_ack) begin
        prog_we_d = 1'b0;
        state_d   = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = (downloading && !dl_q) ? 1'b0 : ovf_q;
    if (drop) ovf_d = 1'b1;
  end

  // Built from next-state values so busy drops right after the GAP cycle
  // that follows the last ack.
  assign busy_d = downloading || (wr_ptr_d != rd_ptr_d) || (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= IDLE;
      out_q     <= '0;
      prog_we_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dl_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      out_q     <= out_d;
      prog_we_q <= prog_we_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      dl_q      <= downloading;
    end
  end

  assign prog_we    = prog_we_q;
  assign prog_addr  = out_q.addr;
  assign prog_data  = out_q.data;
  assign prog_mask  = out_q.mask;
  assign dwnld_busy = busy_q;
  assign full       = full_w;
  assign ovf        = ovf_q;

endmodule
